// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and helpers for the dff_bank_arbiter block: FSM state encodings
// and the modulo-wrap index arithmetic used by the round-robin search.
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int unsigned MIN_REQ = 32'd2;
  localparam int unsigned MAX_REQ = 32'd8;

  // base + off reduced modulo n; off never exceeds n, so one subtraction suffices.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after i_rr_ptr,
// wrapping at NUM_REQ. Shared by the IDLE and COMMIT arbitration points.
module rr_pick
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_winner
);

  logic [IDX_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    o_any    = |i_req;
    o_winner = '0;
    w_idx    = '0;
    for (int unsigned off = NUM_REQ; off >= 32'd1; off--) begin
      w_idx    = IDX_W'(wrap_add(32'(i_rr_ptr), off, NUM_REQ));
      o_winner = i_req[w_idx] ? w_idx : o_winner;
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and load sequencer for one shared DATA_W-bit register:
// IDLE -> GRANT (one-hot gnt for one cycle) -> COMMIT (q loaded, q_valid pulse).
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]   r_grant_id;
  logic [IDX_W-1:0]   w_grant_id_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic [DATA_W-1:0]  r_q;
  logic [DATA_W-1:0]  w_q_nxt;
  logic               r_q_valid;
  logic               w_q_valid_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  logic               w_any;
  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_winner_onehot;
  logic [DATA_W-1:0]  w_sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_winner_onehot = NUM_REQ'(1'b1) << w_winner;

  // Write-data lane of the requester currently holding the grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_data = (r_grant_id == IDX_W'(i)) ? wdata[i*DATA_W +: DATA_W] : w_sel_data;
    end
  end

  // Next-state and next-output decode; rr_ptr only advances when a grant is issued.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = '0;
    w_grant_id_nxt = r_grant_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_q_nxt        = r_q;
    w_q_valid_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_nxt      = w_winner_onehot;
          w_grant_id_nxt = w_winner;
          w_rr_ptr_nxt   = w_winner;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_state_nxt   = ST_COMMIT;
        w_q_nxt       = w_sel_data;
        w_q_valid_nxt = 1'b1;
      end
      ST_COMMIT: begin
        if (w_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_nxt      = w_winner_onehot;
          w_grant_id_nxt = w_winner;
          w_rr_ptr_nxt   = w_winner;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_GRANT) || (w_state_nxt == ST_COMMIT);
  end

  // State and output registers; reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_q        <= w_q_nxt;
      r_q_valid  <= w_q_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign q        = r_q;
  assign q_valid  = r_q_valid;

endmodule
